satellite_fuzz_engine: RTL and testbench

- Parametrised successor to the single-ALU satellite fuzzer: a host-programmable fuzz sequencer driving one stimulus channel into a DUT.
- Generates random or bit-flip-mutated stimulus and issues it with a valid/ready handshake.
- Checks each DUT response against an internal golden model. Mismatches and timeouts go into a crash-log FIFO the central fuzzer reads over the AHB-Lite-style register port.

---
 rtl/satellite_fuzz_engine.sv | 269 ++++++++++++++++++++++++++
 tb/tb_satellite_fuzz_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/satellite_fuzz_engine.sv
// satellite_fuzz_engine: host-programmable fuzz sequencer for a single ALU-like DUT channel.
// Generates random or bit-flip-mutated operands from a Galois LFSR and issues them over a
// valid/ready handshake. Each response is compared against a golden ALU model. Mismatches
// and timeouts go into a crash-log FIFO that the host reads over the register port.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   hsel_i/hwrite_i/haddr_i/hwdata_i register access (write when hsel_i && hwrite_i)
//   hrdata_o                        read data, combinational from haddr_i
//   dut_a_o/dut_b_o/dut_op_o        stimulus operands and opcode
//   dut_valid_o/dut_ready_i         stimulus handshake
//   dut_resp_valid_i/dut_result_i/dut_flag_i  DUT response
//   irq_o                           level, crash log non-empty
module satellite_fuzz_engine #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LOG_DEPTH    = 8,
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            haddr_i,
  input  logic [31:0]           hwdata_i,
  output logic [31:0]           hrdata_o,
  output logic [DATA_WIDTH-1:0] dut_a_o,
  output logic [DATA_WIDTH-1:0] dut_b_o,
  output logic [3:0]            dut_op_o,
  output logic                  dut_valid_o,
  input  logic                  dut_ready_i,
  input  logic                  dut_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] dut_result_i,
  input  logic                  dut_flag_i,
  output logic                  irq_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StGen   = 3'd1;
  localparam logic [2:0] StIssue = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StCheck = 3'd4;
  localparam logic [2:0] StNext  = 3'd5;

  localparam int unsigned PW = $clog2(LOG_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  logic [2:0]            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [31:0]           seed_q, seed_d, lfsr_q, lfsr_d;
  logic [15:0]           iter_q, iter_d, iter_cnt_q, iter_cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]            op_q, op_d;
  logic                  first_q, first_d, flag_q, flag_d;
  logic                  done_q, done_d, ovf_q, ovf_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [CW-1:0]         cnt_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [31:0]           mem_q [LOG_DEPTH];

  logic                  wr_en, start, pop, push, do_push, fifo_full;
  logic [31:0]           entry, s1, s2, seed_val, bit_idx;
  logic [DATA_WIDTH-1:0] flip, exp_res;
  logic                  exp_flag, res_mis, flag_mis;

  assign wr_en     = hsel_i & hwrite_i;
  assign start     = wr_en & (haddr_i == 3'd0) & hwdata_i[4];
  assign fifo_full = (cnt_q == CW'(LOG_DEPTH));
  assign pop       = hsel_i & ~hwrite_i & (haddr_i == 3'd4) & (cnt_q != '0);
  assign do_push   = push & ~fifo_full;
  assign seed_val  = (hwdata_i == 32'h0) ? SEED_DEFAULT : hwdata_i;

  assign s1      = lfsr_step(lfsr_q);
  assign s2      = lfsr_step(s1);
  assign bit_idx = 32'(s1[4:0]) % DATA_WIDTH;
  assign flip    = DATA_WIDTH'(1) << bit_idx;

  // Golden model: ops 0-4 always report flag=1, unused ops expect all-zero.
  always_comb begin
    exp_res  = '0;
    exp_flag = 1'b1;
    case (op_q)
      4'd0:    exp_res = a_q + b_q;
      4'd1:    exp_res = a_q - b_q;
      4'd2:    exp_res = a_q & b_q;
      4'd3:    exp_res = a_q | b_q;
      4'd4:    exp_res = a_q ^ b_q;
      default: exp_flag = 1'b0;
    endcase
  end

  assign res_mis  = (res_q != exp_res);
  assign flag_mis = (flag_q != exp_flag);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    lfsr_d     = lfsr_q;
    iter_d     = iter_q;
    iter_cnt_d = iter_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    flag_d     = flag_q;
    first_d    = first_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    push       = 1'b0;
    entry      = 32'h0;

    if (wr_en) begin
      case (haddr_i)
        3'd0: mode_d = hwdata_i[1:0];
        3'd1: begin
          seed_d = seed_val;
          // A running sequence keeps its LFSR; only the stored seed changes.
          if (state_q == StIdle) lfsr_d = seed_val;
        end
        3'd2: iter_d = hwdata_i[15:0];
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (start && (hwdata_i[1] ^ hwdata_i[0])) begin
          state_d    = StGen;
          done_d     = 1'b0;
          ovf_d      = 1'b0;
          iter_cnt_d = '0;
          first_d    = 1'b1;
        end
      end
      StGen: begin
        if (mode_q == 2'd2) begin
          if (first_q) begin
            a_d  = lfsr_q[DATA_WIDTH-1:0];
            b_d  = ~lfsr_q[DATA_WIDTH-1:0];
            op_d = 4'd0;
          end else if (!iter_cnt_q[0]) begin
            a_d = a_q ^ flip;
          end else begin
            b_d = b_q ^ flip;
          end
          lfsr_d = s1;
        end else begin
          a_d    = s1[DATA_WIDTH-1:0];
          b_d    = s2[DATA_WIDTH-1:0];
          op_d   = {1'b0, s2[30:28]};
          lfsr_d = s2;
        end
        first_d = 1'b0;
        state_d = StIssue;
      end
      StIssue: begin
        if (dut_ready_i) begin
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (dut_resp_valid_i) begin
          res_d   = dut_result_i;
          flag_d  = dut_flag_i;
          state_d = StCheck;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          push    = 1'b1;
          entry   = {4'b1000, op_q, 8'h00, iter_cnt_q};
          state_d = StNext;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCheck: begin
        if (res_mis || flag_mis) begin
          push  = 1'b1;
          entry = {1'b0, flag_mis, res_mis, 1'b0, op_q, 8'h00, iter_cnt_q};
        end
        state_d = StNext;
      end
      StNext: begin
        iter_cnt_d = iter_cnt_q + 16'd1;
        // Mode 0 and 3 both mean idle, so equal mode bits stop the run.
        if (((iter_q != 16'd0) && (iter_cnt_d == iter_q)) || (mode_q[1] == mode_q[0])) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StGen;
        end
      end
      default: state_d = StIdle;
    endcase

    if (push && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= 2'd0;
      seed_q     <= SEED_DEFAULT;
      lfsr_q     <= SEED_DEFAULT;
      iter_q     <= '0;
      iter_cnt_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      flag_q     <= 1'b0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      lfsr_q     <= lfsr_d;
      iter_q     <= iter_d;
      iter_cnt_q <= iter_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      flag_q     <= flag_d;
      first_q    <= first_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry;
  end

  always_comb begin
    case (haddr_i)
      3'd0:    hrdata_o = {30'h0, mode_q};
      3'd1:    hrdata_o = seed_q;
      3'd2:    hrdata_o = {16'h0, iter_q};
      3'd3:    hrdata_o = {state_q, 20'h0, ovf_q, done_q, 7'(cnt_q)};
      3'd4:    hrdata_o = (cnt_q == '0) ? 32'h0 : mem_q[rd_ptr_q];
      3'd5:    hrdata_o = {16'h0, iter_cnt_q};
      default: hrdata_o = 32'h0;
    endcase
  end

  assign dut_a_o     = a_q;
  assign dut_b_o     = b_q;
  assign dut_op_o    = op_q;
  assign dut_valid_o = (state_q == StIssue);
  assign irq_o       = (cnt_q != '0);

endmodule

// File: tb/tb_satellite_fuzz_engine.sv
// Directed bench for satellite_fuzz_engine (DATA_WIDTH=8, LOG_DEPTH=8, TIMEOUT=64).
// A responder process acts as the DUT ALU and can be switched to faulty or silent behaviour.
module tb_satellite_fuzz_engine;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hsel = 1'b0;
  logic          hwrite = 1'b0;
  logic [2:0]    haddr = 3'd0;
  logic [31:0]   hwdata = 32'h0;
  logic [31:0]   hrdata;
  logic [DW-1:0] dut_a, dut_b;
  logic [DW-1:0] dut_result = '0;
  logic [3:0]    dut_op;
  logic          dut_valid;
  logic          dut_ready = 1'b1;
  logic          dut_resp_valid = 1'b0;
  logic          dut_flag = 1'b0;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;
  // 0 correct ALU, 1 result inverted on op4, 2 never respond, 3 result always inverted
  int resp_mode = 0;
  logic [19:0] hs_vec[$];

  satellite_fuzz_engine #(
    .DATA_WIDTH  (DW),
    .LOG_DEPTH   (8),
    .TIMEOUT     (64),
    .SEED_DEFAULT(32'hACE1_0001)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hsel_i          (hsel),
    .hwrite_i        (hwrite),
    .haddr_i         (haddr),
    .hwdata_i        (hwdata),
    .hrdata_o        (hrdata),
    .dut_a_o         (dut_a),
    .dut_b_o         (dut_b),
    .dut_op_o        (dut_op),
    .dut_valid_o     (dut_valid),
    .dut_ready_i     (dut_ready),
    .dut_resp_valid_i(dut_resp_valid),
    .dut_result_i    (dut_result),
    .dut_flag_i      (dut_flag),
    .irq_o           (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b);
    case (op)
      4'd0:    alu = {1'b1, a + b};
      4'd1:    alu = {1'b1, a - b};
      4'd2:    alu = {1'b1, a & b};
      4'd3:    alu = {1'b1, a | b};
      4'd4:    alu = {1'b1, a ^ b};
      default: alu = 9'h000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    hsel = 1'b1; hwrite = 1'b1; haddr = a; hwdata = d;
    tick();
    hsel = 1'b0; hwrite = 1'b0; hwdata = 32'h0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    hsel = 1'b1; hwrite = 1'b0; haddr = a;
    #1;
    d = hrdata;
    tick();
    hsel = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    hsel = 1'b0; haddr = 3'd3;
    do begin
      tick();
      n++;
    end while (hrdata[7] !== 1'b1 && n < max);
    check_eq(tag, 32'(hrdata[7]), 32'h1);
  endtask

  task automatic wait_valid(input int max, input string tag);
    int n = 0;
    while (dut_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(dut_valid), 32'h1);
  endtask

  function automatic logic [19:0] hs_at(input int i);
    return (hs_vec.size() > i) ? hs_vec[i] : 20'hFFFFF;
  endfunction

  // DUT stand-in: answers one cycle after each accepted handshake.
  initial begin : responder
    logic       hs;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [8:0] r;
    forever begin
      @(negedge clk);
      hs = dut_valid && dut_ready && rst_n;
      op = dut_op; a = dut_a; b = dut_b;
      if (hs) hs_vec.push_back({op, a, b});
      @(posedge clk);
      #1;
      r = alu(op, a, b);
      if (hs && resp_mode != 2) begin
        dut_resp_valid = 1'b1;
        dut_result = ((resp_mode == 1 && op == 4'd4) || resp_mode == 3) ? ~r[7:0] : r[7:0];
        dut_flag = r[8];
      end else begin
        dut_resp_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] d;
    logic [19:0] v0;
    logic [19:0] exp_rnd [3];
    logic [19:0] exp_mut [4];
    int n;
    exp_rnd = '{20'h40302, 20'h30103, 20'h60201};
    exp_mut = '{20'h005FA, 20'h005F2, 20'h001F2, 20'h001F0};

    // Reset values
    repeat (3) tick();
    check_eq("rst_valid", 32'(dut_valid), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_stim", {12'h0, dut_op, dut_a, dut_b}, 32'h0);
    rst_n = 1'b1;
    tick();
    rd(3'd3, d); check_eq("rst_status", d, 32'h0);
    rd(3'd5, d); check_eq("rst_iter_cnt", d, 32'h0);
    rd(3'd0, d); check_eq("rst_ctrl", d, 32'h0);
    rd(3'd4, d); check_eq("rst_log_empty", d, 32'h0);

    // Register file behaviour
    wr(3'd1, 32'h0);  rd(3'd1, d); check_eq("seed_zero_default", d, 32'hACE1_0001);
    wr(3'd0, 32'h2);  rd(3'd0, d); check_eq("ctrl_rw", d, 32'h2);
    wr(3'd0, 32'h13); rd(3'd3, d); check_eq("start_mode3_ignored", 32'(d[31:29]), 32'h0);
    rd(3'd0, d); check_eq("ctrl_start_reads0", d, 32'h3);
    rd(3'd7, d); check_eq("unmapped_reads0", d, 32'h0);
    wr(3'd2, 32'h3);  rd(3'd2, d); check_eq("iter_rw", d, 32'h3);

    // Random mode, correct DUT
    resp_mode = 0;
    wr(3'd1, 32'h1);
    hs_vec.delete();
    wr(3'd0, 32'h11);
    check_eq("lat_gen_valid0", 32'(dut_valid), 32'h0);
    tick();
    check_eq("lat_issue_valid1", 32'(dut_valid), 32'h1);
    wait_done(100, "rnd_done");
    check_eq("rnd_hs_count", hs_vec.size(), 32'd3);
    for (int i = 0; i < 3; i++) check_eq($sformatf("rnd_vec%0d", i), 32'(hs_at(i)), 32'(exp_rnd[i]));
    rd(3'd5, d); check_eq("rnd_iter_cnt", d, 32'h3);
    rd(3'd3, d); check_eq("rnd_status", d, 32'h0000_0080);
    check_eq("rnd_irq", 32'(irq), 32'h0);

    // Random mode, DUT result wrong on op4
    resp_mode = 1;
    wr(3'd1, 32'h1);
    wr(3'd0, 32'h11);
    wait_done(100, "fault_done");
    rd(3'd3, d); check_eq("fault_status", d, 32'h0000_0081);
    check_eq("fault_irq", 32'(irq), 32'h1);
    rd(3'd4, d); check_eq("fault_log0", d, 32'h2400_0000);
    rd(3'd3, d); check_eq("fault_status_popped", d, 32'h0000_0080);
    check_eq("fault_irq_clear", 32'(irq), 32'h0);
    rd(3'd4, d); check_eq("fault_log_empty", d, 32'h0);

    // Silent DUT: timeouts
    resp_mode = 2;
    wr(3'd2, 32'h2);
    wr(3'd1, 32'h1);
    wr(3'd0, 32'h11);
    wait_valid(10, "tmo_valid");
    n = 0;
    do begin
      tick();
      n++;
    end while (irq !== 1'b1 && n < 200);
    check_eq("tmo_latency", n - 1, 32'd64);
    wait_done(200, "tmo_done");
    rd(3'd3, d); check_eq("tmo_status", d, 32'h0000_0082);
    rd(3'd4, d); check_eq("tmo_log0", d, 32'h8400_0000);
    rd(3'd4, d); check_eq("tmo_log1", d, 32'h8300_0001);

    // Mutate mode
    resp_mode = 0;
    wr(3'd2, 32'h4);
    wr(3'd1, 32'h5);
    hs_vec.delete();
    wr(3'd0, 32'h12);
    wait_done(100, "mut_done");
    check_eq("mut_hs_count", hs_vec.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("mut_vec%0d", i), 32'(hs_at(i)), 32'(exp_mut[i]));
    rd(3'd5, d); check_eq("mut_iter_cnt", d, 32'h4);
    rd(3'd3, d); check_eq("mut_status", d, 32'h0000_0080);

    // Endless run against an always-wrong DUT: FIFO fills and overflows
    resp_mode = 3;
    wr(3'd2, 32'h0);
    wr(3'd1, 32'h1);
    wr(3'd0, 32'h11);
    hsel = 1'b0; haddr = 3'd3;
    n = 0;
    do begin
      tick();
      n++;
    end while (hrdata[8] !== 1'b1 && n < 300);
    check_eq("ovf_set", 32'(hrdata[8]), 32'h1);
    check_eq("ovf_count_sat", 32'(hrdata[6:0]), 32'd8);
    check_eq("ovf_irq", 32'(irq), 32'h1);
    wr(3'd0, 32'h0);
    wait_done(50, "stop_done");
    rd(3'd3, d); check_eq("stop_status", d, 32'h0000_0188);
    rd(3'd4, d); check_eq("ovf_log0", d, 32'h2400_0000);
    rd(3'd4, d); check_eq("ovf_log1", d, 32'h2300_0001);
    rd(3'd4, d); check_eq("ovf_log2", d, 32'h2600_0002);

    // Back-pressure in ISSUE, then reset while in WAIT
    resp_mode = 0;
    dut_ready = 1'b0;
    wr(3'd2, 32'h1);
    wr(3'd0, 32'h11);
    wait_valid(10, "bp_valid");
    v0 = {dut_op, dut_a, dut_b};
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("bp_valid_hold%0d", i), 32'(dut_valid), 32'h1);
      check_eq($sformatf("bp_stim_hold%0d", i), 32'({dut_op, dut_a, dut_b}), 32'(v0));
    end
    rd(3'd3, d); check_eq("bp_status", d, 32'h4000_0005);
    resp_mode = 2;
    dut_ready = 1'b1;
    tick();
    rd(3'd3, d); check_eq("wait_state", 32'(d[31:29]), 32'h3);
    rst_n = 1'b0;
    tick();
    check_eq("midrst_valid", 32'(dut_valid), 32'h0);
    check_eq("midrst_stim", {12'h0, dut_op, dut_a, dut_b}, 32'h0);
    check_eq("midrst_irq", 32'(irq), 32'h0);
    rd(3'd3, d); check_eq("midrst_status", d, 32'h0);
    rd(3'd5, d); check_eq("midrst_iter_cnt", d, 32'h0);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
